// File: rtl/sram_arb_pkg.sv
//------------------------------------------------------------------------------
// Module  : sram_arb_pkg
// Brief   : Shared types and constants for the two-port SRAM arbiter.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package sram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    localparam logic PORT_DATA = 1'b0;
    localparam logic PORT_INST = 1'b1;

    localparam int DEF_ADDR_W         = 19;
    localparam int DEF_WDATA_W        = 32;
    localparam int DEF_RDATA_W        = 64;
    localparam int DEF_TIMEOUT_CYCLES = 16;

endpackage

`default_nettype wire

// File: rtl/sram_arbiter_if.sv
//------------------------------------------------------------------------------
// Module  : sram_arbiter_if
// Brief   : Requester and controller signals of the SRAM arbiter; the slave
//           modport is the arbiter's view, master is the surrounding system.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sram_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int WDATA_W = DEF_WDATA_W,
    parameter int RDATA_W = DEF_RDATA_W
);
    logic               p0_req;
    logic               p0_we;
    logic [ADDR_W-1:0]  p0_addr;
    logic [WDATA_W-1:0] p0_wdata;
    logic               p0_done;
    logic [RDATA_W-1:0] p0_rdata;

    logic               p1_req;
    logic               p1_we;
    logic [ADDR_W-1:0]  p1_addr;
    logic [WDATA_W-1:0] p1_wdata;
    logic               p1_done;
    logic [RDATA_W-1:0] p1_rdata;

    logic               mem_write_en;
    logic               mem_read_en;
    logic [ADDR_W-1:0]  mem_address;
    logic [WDATA_W-1:0] mem_write_data;
    logic [RDATA_W-1:0] mem_read_data;
    logic               mem_ready;

    logic               busy;
    logic               err;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_done, p0_rdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_done, p1_rdata,
        output mem_write_en, mem_read_en, mem_address, mem_write_data,
        input  mem_read_data, mem_ready,
        output busy, err
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_done, p0_rdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_done, p1_rdata,
        input  mem_write_en, mem_read_en, mem_address, mem_write_data,
        output mem_read_data, mem_ready,
        input  busy, err
    );

endinterface

`default_nettype wire

// File: rtl/sram_arbiter_rr_arbiter2.sv
//------------------------------------------------------------------------------
// Module  : rr_arbiter2
// Brief   : Combinational two-input round-robin grant; on a tie the port
//           not served last wins.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter2 (
    input  wire logic i_last_grant,
    input  wire logic i_req0,
    input  wire logic i_req1,
    output logic      o_any,
    output logic      o_gnt
);

    assign o_any = i_req0 | i_req1;
    assign o_gnt = (i_req0 & i_req1) ? ~i_last_grant : i_req1;

endmodule

`default_nettype wire

// File: rtl/sram_arbiter.sv
//------------------------------------------------------------------------------
// Module  : sram_arbiter
// Brief   : Round-robin sharing of one SRAM controller between the data port
//           (0) and the instruction port (1). Optional macro
//           SRAM_ARB_TIMEOUT_EN bounds the wait for mem_ready.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int WDATA_W        = DEF_WDATA_W,
    parameter int RDATA_W        = DEF_RDATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
)(
    input  wire logic     clk,
    input  wire logic     rst,
    sram_arbiter_if.slave bus
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_ISSUE = ST_ISSUE;
    localparam logic [1:0] S_WAIT  = ST_WAIT;
    localparam logic [1:0] S_DONE  = ST_DONE;

    logic [1:0]         r_state;
    logic               r_gnt;
    logic               r_last;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [WDATA_W-1:0] r_wdata;
    logic [RDATA_W-1:0] r_rdata;

    logic w_any;
    logic w_gnt;
    logic w_active;
    logic w_done;

    rr_arbiter2 u_rr (
        .i_last_grant (r_last),
        .i_req0       (bus.p0_req),
        .i_req1       (bus.p1_req),
        .o_any        (w_any),
        .o_gnt        (w_gnt)
    );

`ifdef SRAM_ARB_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TCNT_W-1:0] r_tcnt;
    logic              r_err;

    // r_tcnt holds the number of WAIT cycles already elapsed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tcnt <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (r_state == S_ISSUE) begin
                r_tcnt <= '0;
            end else if (r_state == S_WAIT && !bus.mem_ready) begin
                if (r_tcnt == TCNT_W'(TIMEOUT_CYCLES - 1))
                    r_err <= 1'b1;
                else
                    r_tcnt <= r_tcnt + 1'b1;
            end
        end
    end

    wire logic w_timeout = (r_tcnt == TCNT_W'(TIMEOUT_CYCLES - 1));
    assign bus.err = r_err;
`else
    wire logic w_timeout = 1'b0;
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_gnt   <= PORT_DATA;
            r_last  <= PORT_INST;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state <= S_ISSUE;
                        r_gnt   <= w_gnt;
                        r_we    <= w_gnt ? bus.p1_we    : bus.p0_we;
                        r_addr  <= w_gnt ? bus.p1_addr  : bus.p0_addr;
                        r_wdata <= w_gnt ? bus.p1_wdata : bus.p0_wdata;
                    end
                end
                // Controller's idle ready is stale here, so it is not sampled
                S_ISSUE: r_state <= S_WAIT;
                S_WAIT: begin
                    if (bus.mem_ready) begin
                        r_state <= S_DONE;
                        r_rdata <= bus.mem_read_data;
                        r_last  <= r_gnt;
                    end else if (w_timeout) begin
                        r_state <= S_DONE;
                        r_rdata <= '0;
                        r_last  <= r_gnt;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_active = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign w_done   = (r_state == S_DONE);

    assign bus.mem_read_en    = w_active & ~r_we;
    assign bus.mem_write_en   = w_active &  r_we;
    assign bus.mem_address    = r_addr;
    assign bus.mem_write_data = r_wdata;

    assign bus.busy     = (r_state != S_IDLE);
    assign bus.p0_done  = w_done & (r_gnt == PORT_DATA);
    assign bus.p1_done  = w_done & (r_gnt == PORT_INST);
    assign bus.p0_rdata = r_rdata;
    assign bus.p1_rdata = r_rdata;

endmodule

`default_nettype wire

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single SRAM controller between two requesters: port 0 = MEM-stage data access, port 1 = instruction-fetch/refill.
- Round-robin arbitration; one transaction in flight at a time.
- Sequences the controller's enable/ready handshake so each granted request issues exactly once.
- Returns 64-bit read data and a one-cycle done pulse to the granted port only.

Parameters:
- ADDR_W, 19, byte address width passed through to the controller unmodified.
- WDATA_W, 32, write data width.
- RDATA_W, 64, read data width.
- TIMEOUT_CYCLES, 16, busy-cycle limit; used only with SRAM_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- p0_req  in  1  port 0 request; held high until p0_done
- p0_we  in  1  port 0 write (1) / read (0)
- p0_addr  in  ADDR_W  port 0 byte address
- p0_wdata  in  WDATA_W  port 0 write data
- p0_done  out  1  port 0 completion pulse
- p0_rdata  out  RDATA_W  port 0 read data, valid with p0_done
- p1_req, p1_we, p1_addr, p1_wdata, p1_done, p1_rdata: same as port 0, for port 1
- mem_write_en  out  1  controller write enable
- mem_read_en  out  1  controller read enable
- mem_address  out  ADDR_W  controller address
- mem_write_data  out  WDATA_W  controller write data
- mem_read_data  in  RDATA_W  controller read data
- mem_ready  in  1  controller ready
- busy  out  1  high in every state except IDLE
- err  out  1  timeout pulse (SRAM_ARB_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
- States:
  - IDLE: no transaction.
  - ISSUE: one cycle; enables asserted.
  - WAIT: enables asserted until mem_ready=1.
  - DONE: one cycle; enables low, done pulse.
- IDLE -> ISSUE on any req. Grant selects the port:
  - Only one port requesting: grant it.
  - Both requesting: grant the port not served last.
  - last_grant resets to 1, so port 0 wins the first tie.
- On the IDLE->ISSUE edge, latch gnt, we, addr and wdata into registers. Requester changes after the grant are ignored.
- Controller outputs come only from the latched registers:
  - mem_read_en = !we_q in ISSUE/WAIT.
  - mem_write_en = we_q in ISSUE/WAIT.
  - Both enables are 0 in IDLE and DONE.
- ISSUE -> WAIT unconditionally. mem_ready is ignored in ISSUE, because the controller's idle ready drops combinationally once an enable rises.
- WAIT -> DONE on mem_ready=1. On that edge, register mem_read_data into rdata_q (writes register it too; value is don't-care) and set last_grant = gnt.
- DONE:
  - pd_done of the granted port = 1 for exactly one cycle; the other port's done stays 0.
  - pX_rdata = rdata_q for both ports; consumers qualify it with their own done.
  - DONE -> IDLE.
- Enables are low in DONE, so the controller, which returns to its idle state after its ready cycle, cannot restart the transaction.
- Minimum latency: request in IDLE to done pulse = 2 + controller busy cycles. With the current controller, the done pulse follows the ready cycle by exactly 1 cycle.
- A requester still high in the cycle after its done is treated as a new request. Requesters must drop req in the cycle after done unless they want another access.
- Back-to-back: a request present in IDLE is granted that cycle; the minimum gap between done pulses is 3 cycles.
- Reset (also mid-transaction): state=IDLE, enables 0, both done 0, busy 0, err 0, rdata_q 0, last_grant 1. The in-flight access is abandoned; the requester must reissue.

Optional Feature:
- Macro SRAM_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - On reaching TIMEOUT_CYCLES with mem_ready still 0: go to DONE, pulse err together with the granted port's done, rdata_q = 0.
  - A WAIT cycle where mem_ready=1 and the limit is reached at the same time counts as normal completion, with no err.
- Undefined: no counter, err tied 0, WAIT waits indefinitely.

Decomposition:
- Package sram_arb_pkg:
  - State enum (IDLE, ISSUE, WAIT, DONE).
  - Port index constants PORT_DATA=0, PORT_INST=1.
  - Default widths.
- One natural sub-module: rr_arbiter2, a combinational 2-input round-robin grant that takes last_grant and the two requests.
- Registers stay in the top level.

Test Plan:
- Single read: p0_req, p0_we=0, p0_addr=0x400; model ready after 5 cycles with data 0xDEADBEEF_01234567 -> mem_read_en high in ISSUE/WAIT only; p0_done one pulse; p0_rdata=0xDEADBEEF_01234567; p1_done stays 0.
- Single write: p1_req, p1_we=1, addr=0x408, wdata=0xA5A5A5A5 -> mem_write_en high, mem_write_data=0xA5A5A5A5, mem_address=0x408 for the whole transaction; p1_done pulse.
- Contention: p0 and p1 request in the same cycle after reset, both held continuously -> grant order 0,1,0,1; done pulses alternate, at least 3 cycles apart.
- Request latching: change p0_addr from 0x400 to 0x500 during WAIT -> mem_address stays 0x400.
- Reset during WAIT -> next cycle all enables 0, busy 0; reissued request completes normally with p0 winning a tie.
- With SRAM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, mem_ready held 0 -> err and p0_done pulse together after 16 WAIT cycles; rdata=0; arbiter returns to IDLE.
